// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared sizes, unit indices and slot state encoding
package issue_scheduler_pkg;
  localparam int NREG   = 64;
  localparam int NUNIT  = 8;
  localparam int STALLW = 32;
  localparam int RW     = $clog2(NREG);
  localparam int UW     = $clog2(NUNIT);
  localparam logic [UW-1:0] UNIT_ALU0 = 3'd0;
  localparam logic [UW-1:0] UNIT_ALU1 = 3'd1;
  localparam logic [UW-1:0] UNIT_MUL  = 3'd2;
  localparam logic [UW-1:0] UNIT_DIV  = 3'd3;
  localparam logic [UW-1:0] UNIT_LD   = 3'd4;
  localparam logic [UW-1:0] UNIT_ST   = 3'd5;
  localparam logic [UW-1:0] UNIT_BR   = 3'd6;
  localparam logic [UW-1:0] UNIT_FPU  = 3'd7;
  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} slot_e;
endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// sched_scoreboard: per-register busy bits with writeback bypass and four hazard read ports
module sched_scoreboard
  import issue_scheduler_pkg::*;
#(
  parameter int NR = NREG,
  parameter int W  = $clog2(NR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb0_en,
  input  logic [W-1:0]      wb0_rn,
  input  logic              wb1_en,
  input  logic [W-1:0]      wb1_rn,
  input  logic              set0_en,
  input  logic [W-1:0]      set0_rn,
  input  logic              set1_en,
  input  logic [W-1:0]      set1_rn,
  input  logic [3:0][W-1:0] rd_rn,
  output logic [3:0]        eb
);
  logic [NR-1:0] busy_q, busy_d, eb_all;
  // writeback clears are visible the same cycle; issue sets override clears; register 0 stays free
  always_comb begin
    busy_d = '0;
    eb_all = '0;
    eb     = '0;
    for (int r = 1; r < NR; r++) begin
      eb_all[r] = busy_q[r] & ~(wb0_en && wb0_rn == W'(r)) & ~(wb1_en && wb1_rn == W'(r));
      busy_d[r] = eb_all[r] | (set0_en && set0_rn == W'(r)) | (set1_en && set1_rn == W'(r));
    end
    for (int k = 0; k < 4; k++) eb[k] = eb_all[rd_rn[k]];
  end
  // busy bit array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: decode slot FSM, hazard/unit-ready issue gating and stall counter
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int NREG   = issue_scheduler_pkg::NREG,
  parameter int NUNIT  = issue_scheduler_pkg::NUNIT,
  parameter int STALLW = issue_scheduler_pkg::STALLW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  output logic                     allow_advance,
  input  logic [$clog2(NUNIT)-1:0] dec_unit,
  input  logic [$clog2(NREG)-1:0]  dec_r1_rn,
  input  logic [$clog2(NREG)-1:0]  dec_r2_rn,
  input  logic [$clog2(NREG)-1:0]  dec_rd_rn,
  input  logic [$clog2(NREG)-1:0]  dec_rd2_rn,
  input  logic                     dec_wr_rd,
  input  logic                     dec_wr_rd2,
  input  logic [NUNIT-1:0]         unit_ready,
  output logic                     issue_valid,
  output logic [NUNIT-1:0]         issue_unit,
  input  logic                     wb0_en,
  input  logic [$clog2(NREG)-1:0]  wb0_rn,
  input  logic                     wb1_en,
  input  logic [$clog2(NREG)-1:0]  wb1_rn,
  input  logic                     flush,
  output logic [STALLW-1:0]        stall_count
);
  slot_e             state_q, state_d;
  logic [STALLW-1:0] stall_q, stall_d;
  logic [3:0]        eb;
  logic              hazard;

  sched_scoreboard #(.NR(NREG)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb0_en  (wb0_en),
    .wb0_rn  (wb0_rn),
    .wb1_en  (wb1_en),
    .wb1_rn  (wb1_rn),
    .set0_en (issue_valid & dec_wr_rd),
    .set0_rn (dec_rd_rn),
    .set1_en (issue_valid & dec_wr_rd2),
    .set1_rn (dec_rd2_rn),
    .rd_rn   ({dec_rd2_rn, dec_rd_rn, dec_r2_rn, dec_r1_rn}),
    .eb      (eb)
  );

  // issue decision, decode handshake, next slot state and stall accounting
  always_comb begin
    hazard        = eb[0] | eb[1] | (dec_wr_rd & eb[2]) | (dec_wr_rd2 & eb[3]);
    issue_valid   = (state_q == HELD) & ~flush & ~hazard & unit_ready[dec_unit];
    issue_unit    = issue_valid ? NUNIT'(1) << dec_unit : '0;
    allow_advance = rst_n & (flush | (state_q == EMPTY) | issue_valid);
    state_d       = flush ? EMPTY : ((state_q == EMPTY) || issue_valid) ? (fetch_valid ? HELD : EMPTY) : HELD;
    stall_d       = ((state_q == HELD) && !issue_valid && !flush && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end
  // slot state and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: table-driven directed check of issue gating, scoreboard and slot FSM
module tb_issue_scheduler;
  typedef struct {
    logic        fv;
    logic [2:0]  unit;
    logic [5:0]  r1, r2, rd, rd2;
    logic        wr, wr2;
    logic [7:0]  rdy;
    logic        w0e;
    logic [5:0]  w0;
    logic        w1e;
    logic [5:0]  w1;
    logic        fl;
    logic        e_allow, e_issue;
    logic [7:0]  e_unit;
    logic [31:0] e_stall;
  } vec_t;

  logic        clk = 0, rst_n = 0;
  logic        fetch_valid = 0, dec_wr_rd = 0, dec_wr_rd2 = 0, wb0_en = 0, wb1_en = 0, flush = 0;
  logic [2:0]  dec_unit = 0;
  logic [5:0]  dec_r1_rn = 0, dec_r2_rn = 0, dec_rd_rn = 0, dec_rd2_rn = 0, wb0_rn = 0, wb1_rn = 0;
  logic [7:0]  unit_ready = 8'hFF;
  logic        allow_advance, issue_valid;
  logic [7:0]  issue_unit;
  logic [31:0] stall_count;
  int          n_tests = 0, n_fail = 0;
  logic [63:0] shadow = '0;
  vec_t        tbl[$];

  issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .allow_advance(allow_advance),
    .dec_unit(dec_unit), .dec_r1_rn(dec_r1_rn), .dec_r2_rn(dec_r2_rn), .dec_rd_rn(dec_rd_rn),
    .dec_rd2_rn(dec_rd2_rn), .dec_wr_rd(dec_wr_rd), .dec_wr_rd2(dec_wr_rd2), .unit_ready(unit_ready),
    .issue_valid(issue_valid), .issue_unit(issue_unit), .wb0_en(wb0_en), .wb0_rn(wb0_rn),
    .wb1_en(wb1_en), .wb1_rn(wb1_rn), .flush(flush), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fv, input logic [2:0] unit, input logic [5:0] r1, r2,
                              input logic [5:0] rd, input logic wr, input logic [5:0] rd2, input logic wr2,
                              input logic [7:0] rdy, input logic w0e, input logic [5:0] w0,
                              input logic w1e, input logic [5:0] w1, input logic fl,
                              input logic ea, input logic ei, input logic [7:0] eu, input logic [31:0] es);
    vec_t v;
    v.fv = fv; v.unit = unit; v.r1 = r1; v.r2 = r2; v.rd = rd; v.wr = wr; v.rd2 = rd2; v.wr2 = wr2;
    v.rdy = rdy; v.w0e = w0e; v.w0 = w0; v.w1e = w1e; v.w1 = w1; v.fl = fl;
    v.e_allow = ea; v.e_issue = ei; v.e_unit = eu; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    fetch_valid = v.fv; dec_unit = v.unit; dec_r1_rn = v.r1; dec_r2_rn = v.r2;
    dec_rd_rn = v.rd; dec_wr_rd = v.wr; dec_rd2_rn = v.rd2; dec_wr_rd2 = v.wr2;
    unit_ready = v.rdy; wb0_en = v.w0e; wb0_rn = v.w0; wb1_en = v.w1e; wb1_rn = v.w1; flush = v.fl;
  endtask

  initial begin
    // independent stream, one issue per cycle
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 1,0,8'h00,0));
    tbl.push_back(mk(1,1, 1,2,10,1, 0,0, 8'hFF, 0,0, 0,0, 0, 1,1,8'h02,0));
    tbl.push_back(mk(1,2, 3,4,11,1, 0,0, 8'hFF, 0,0, 0,0, 0, 1,1,8'h04,0));
    tbl.push_back(mk(1,0, 1,2,12,1,13,1, 8'hFF, 0,0, 0,0, 0, 1,1,8'h01,0));
    // RAW on r5 resolved by wb0 in the issuing cycle
    tbl.push_back(mk(1,4, 6,0, 5,1, 0,0, 8'hFF, 0,0, 0,0, 0, 1,1,8'h10,0));
    tbl.push_back(mk(1,5, 5,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,0));
    tbl.push_back(mk(1,5, 5,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,1));
    tbl.push_back(mk(1,5, 5,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,2));
    tbl.push_back(mk(1,5, 5,0, 0,0, 0,0, 8'hFF, 1,5, 0,0, 0, 1,1,8'h20,3));
    // unit 3 not ready for four cycles
    tbl.push_back(mk(1,3, 1,0, 7,1, 0,0, 8'hF7, 0,0, 0,0, 0, 0,0,8'h00,3));
    tbl.push_back(mk(1,3, 1,0, 7,1, 0,0, 8'hF7, 0,0, 0,0, 0, 0,0,8'h00,4));
    tbl.push_back(mk(1,3, 1,0, 7,1, 0,0, 8'hF7, 0,0, 0,0, 0, 0,0,8'h00,5));
    tbl.push_back(mk(1,3, 1,0, 7,1, 0,0, 8'hF7, 0,0, 0,0, 0, 0,0,8'h00,6));
    tbl.push_back(mk(1,3, 1,0, 7,1, 0,0, 8'hFF, 0,0, 0,0, 0, 1,1,8'h08,7));
    // set of r7 beats wb1 clear of r7; reader then stalls
    tbl.push_back(mk(1,6, 0,0, 7,1, 0,0, 8'hFF, 0,0, 1,7, 0, 1,1,8'h40,7));
    tbl.push_back(mk(1,7, 7,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,7));
    // flush while held with hazard, busy kept
    tbl.push_back(mk(1,7, 7,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 1, 1,0,8'h00,8));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 1,0,8'h00,8));
    tbl.push_back(mk(1,7, 7,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,8));
    tbl.push_back(mk(1,7, 7,0, 0,0, 0,0, 8'hFF, 1,7, 1,7, 0, 1,1,8'h80,9));
    // r0 never becomes busy
    tbl.push_back(mk(1,1, 0,0, 0,1, 0,1, 8'hFF, 0,0, 0,0, 0, 1,1,8'h02,9));
    tbl.push_back(mk(1,2, 0,0, 0,1, 0,0, 8'hFF, 0,0, 0,0, 0, 1,1,8'h04,9));
    // rd == rd2 sets a single bit, one wb clears it
    tbl.push_back(mk(1,0, 0,0,20,1,20,1, 8'hFF, 0,0, 0,0, 0, 1,1,8'h01,9));
    tbl.push_back(mk(1,1,20,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,9));
    tbl.push_back(mk(0,1,20,0, 0,0, 0,0, 8'hFF, 1,20,0,0, 0, 1,1,8'h02,10));
    tbl.push_back(mk(0,1,20,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 1,0,8'h00,10));
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 1,0,8'h00,10));
    // WAW gated by write flags
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 1,0,8'h00,10));
    tbl.push_back(mk(1,2, 0,0,10,1, 0,0, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,10));
    tbl.push_back(mk(1,2, 0,0,10,0, 0,0, 8'hFF, 0,0, 0,0, 0, 1,1,8'h04,11));
    tbl.push_back(mk(1,3, 0,0, 0,0,13,1, 8'hFF, 0,0, 0,0, 0, 0,0,8'h00,11));
    tbl.push_back(mk(0,3, 0,0, 0,0,13,1, 8'hFF, 0,0, 1,13,0, 1,1,8'h08,12));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 8'hFF, 0,0, 0,0, 0, 1,0,8'h00,12));

    fetch_valid = 1; flush = 1;
    #12;
    chk("rst_allow", 32'(allow_advance), 0);
    chk("rst_issue", 32'(issue_valid), 0);
    chk("rst_unit", 32'(issue_unit), 0);
    chk("rst_stall", stall_count, 0);
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d_allow", i), 32'(allow_advance), 32'(tbl[i].e_allow));
      chk($sformatf("v%0d_issue", i), 32'(issue_valid), 32'(tbl[i].e_issue));
      chk($sformatf("v%0d_unit", i), 32'(issue_unit), 32'(tbl[i].e_unit));
      chk($sformatf("v%0d_stall", i), stall_count, tbl[i].e_stall);
      if ((tbl[i].w0e && !shadow[tbl[i].w0]) || (tbl[i].w1e && !shadow[tbl[i].w1])) begin
        n_fail++;
        $display("FAIL v%0d_wb_nonbusy: writeback to a register not busy", i);
      end
      if (tbl[i].w0e) shadow[tbl[i].w0] = 0;
      if (tbl[i].w1e) shadow[tbl[i].w1] = 0;
      if (tbl[i].e_issue && tbl[i].wr) shadow[tbl[i].rd] = 1;
      if (tbl[i].e_issue && tbl[i].wr2) shadow[tbl[i].rd2] = 1;
      shadow[0] = 0;
      @(negedge clk);
    end
    // asynchronous reset mid-cycle clears the counter and gates outputs
    fetch_valid = 1; flush = 1;
    #1;
    chk("pre_arst_allow", 32'(allow_advance), 1);
    rst_n = 0;
    #1;
    chk("arst_allow", 32'(allow_advance), 0);
    chk("arst_issue", 32'(issue_valid), 0);
    chk("arst_stall", stall_count, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
